// File: rtl/mem_port_arbiter.sv
// Arbitrates CPU instruction fetch and load/store onto a single memory port with req/ready handshake.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default is fixed D-over-IF priority).
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic [1:0]        d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic [1:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t            state_q;
    logic              grant_d_q;      // current access belongs to the load/store side
    logic [CNT_W-1:0]  wait_q;
    logic [CNT_W-1:0]  wait_d;
    logic              mem_req_q;
    logic [1:0]        mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic              err_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              pick_d;
    logic              timeout_hit;
    logic              access_done;
    logic [DATA_W-1:0] resp_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_grant_d_q;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        wait_d      = wait_q + CNT_W'(1);
        timeout_hit = (TIMEOUT_CYC != 0) && (wait_d == CNT_W'(TIMEOUT_CYC));
        access_done = mem_ready_i || timeout_hit;
        resp_data   = '0;
        if (mem_ready_i && (mem_we_q == 2'b00)) begin
            resp_data = mem_rdata_i;
        end
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = d_req_i && (!if_req_i || !last_grant_d_q);
`else
        pick_d = d_req_i;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            grant_d_q   <= 1'b0;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d_q <= 1'b0;
`endif
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (if_req_i || d_req_i) begin
                        state_q   <= ST_GRANT;
                        grant_d_q <= pick_d;
                        wait_q    <= '0;
                        mem_req_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d_q <= pick_d;
`endif
                        if (pick_d) begin
                            mem_we_q    <= d_we_i;
                            mem_addr_q  <= d_addr_i;
                            mem_wdata_q <= d_wdata_i;
                        end else begin
                            mem_we_q    <= 2'b00;
                            mem_addr_q  <= if_addr_i;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                ST_GRANT: begin
                    if (access_done) begin
                        // Completion and timeout abort share one exit; err flags the abort.
                        state_q   <= ST_RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 2'b00;
                        err_q     <= !mem_ready_i;
                        if (grant_d_q) begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= resp_data;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= resp_data;
                        end
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ack_o    = if_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_ack_o     = d_ack_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; honours ARB_ROUND_ROBIN_EN when defined.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic [1:0]  d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_ack_o;
    logic [31:0] d_rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic [1:0]  mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    int vec_cnt = 0;
    int err_cnt = 0;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(15)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_ack_o   (if_ack_o),
        .if_rdata_o (if_rdata_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_ack_o    (d_ack_o),
        .d_rdata_o  (d_rdata_o),
        .err_o      (err_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Control status packed as {mem_req, mem_we[1:0], if_ack, d_ack, err}.
    function automatic logic [5:0] status();
        return {mem_req_o, mem_we_o, if_ack_o, d_ack_o, err_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 2'b00;
        if_addr_i = '0; d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0; mem_ready_i = 1'b0;
        tick(); tick();
        vec_cnt++;
        if (status() !== 6'b0_00_000) begin
            err_cnt++; $display("FAIL reset_status: got %b expected %b", status(), 6'b0_00_000);
        end
        vec_cnt++;
        if ({mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o} !== 128'h0) begin
            err_cnt++; $display("FAIL reset_data: got %h expected 0", {mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o});
        end
        rst_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
        tick();
        vec_cnt++;
        if ({status(), mem_addr_o} !== {6'b1_00_000, 32'h100}) begin
            err_cnt++; $display("FAIL reset_pre_grant: got %b/%h expected 100000/00000100", status(), mem_addr_o);
        end
        rst_i = 1'b1; if_req_i = 1'b0; mem_ready_i = 1'b1;
        tick();
        vec_cnt++;
        if ({status(), mem_addr_o} !== {6'b0_00_000, 32'h0}) begin
            err_cnt++; $display("FAIL reset_mid_grant: got %b/%h expected 000000/00000000", status(), mem_addr_o);
        end
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vec_cnt++;
            if (status() !== 6'b0_00_000) begin
                err_cnt++; $display("FAIL reset_idle_%0d: got %b expected %b", i, status(), 6'b0_00_000);
            end
        end
        mem_ready_i = 1'b0;
    endtask

    task automatic test_fetch_zero_wait();
        if_req_i = 1'b1; if_addr_i = 32'h0000_0100; mem_ready_i = 1'b1; mem_rdata_i = 32'h0050_0093;
        tick();
        vec_cnt++;
        if ({status(), mem_addr_o, mem_wdata_o} !== {6'b1_00_000, 32'h100, 32'h0}) begin
            err_cnt++; $display("FAIL fetch_grant: got %b/%h/%h expected 100000/00000100/00000000", status(), mem_addr_o, mem_wdata_o);
        end
        tick();
        if_req_i = 1'b0;
        vec_cnt++;
        if ({status(), if_rdata_o} !== {6'b0_00_100, 32'h0050_0093}) begin
            err_cnt++; $display("FAIL fetch_ack: got %b/%h expected 000100/00500093", status(), if_rdata_o);
        end
        mem_ready_i = 1'b0;
        tick();
        vec_cnt++;
        if ({status(), if_rdata_o} !== {6'b0_00_000, 32'h0050_0093}) begin
            err_cnt++; $display("FAIL fetch_after: got %b/%h expected 000000/00500093", status(), if_rdata_o);
        end
    endtask

    task automatic test_store_wait_states();
        d_req_i = 1'b1; d_we_i = 2'b11; d_addr_i = 32'h0000_2000; d_wdata_i = 32'hDEAD_BEEF;
        mem_ready_i = 1'b0; mem_rdata_i = 32'h1234_5678;
        for (int i = 1; i <= 4; i++) begin
            tick();
            vec_cnt++;
            if ({status(), mem_addr_o, mem_wdata_o} !== {6'b1_11_000, 32'h2000, 32'hDEAD_BEEF}) begin
                err_cnt++; $display("FAIL store_wait_%0d: got %b/%h/%h expected 111000/00002000/deadbeef", i, status(), mem_addr_o, mem_wdata_o);
            end
            if (i == 4) mem_ready_i = 1'b1;
        end
        tick();
        d_req_i = 1'b0; mem_ready_i = 1'b0;
        vec_cnt++;
        if ({status(), d_rdata_o, if_rdata_o} !== {6'b0_00_010, 32'h0, 32'h0050_0093}) begin
            err_cnt++; $display("FAIL store_ack: got %b/%h/%h expected 000010/00000000/00500093", status(), d_rdata_o, if_rdata_o);
        end
        tick();
        vec_cnt++;
        if (status() !== 6'b0_00_000) begin
            err_cnt++; $display("FAIL store_after: got %b expected 000000", status());
        end
    endtask

    task automatic arb_round(input logic first_d, input int round);
        logic [31:0] first_addr, second_addr, first_data, second_data;
        logic [5:0]  first_ack, second_ack;
        first_addr  = first_d ? 32'h0000_3000 : 32'h0000_0104;
        second_addr = first_d ? 32'h0000_0104 : 32'h0000_3000;
        first_data  = first_d ? 32'hAAAA_0001 : 32'h0000_0013;
        second_data = first_d ? 32'h0000_0013 : 32'hAAAA_0001;
        first_ack   = first_d ? 6'b0_00_010 : 6'b0_00_100;
        second_ack  = first_d ? 6'b0_00_100 : 6'b0_00_010;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0104;
        d_req_i = 1'b1; d_we_i = 2'b00; d_addr_i = 32'h0000_3000; d_wdata_i = 32'h5555_5555;
        mem_ready_i = 1'b1; mem_rdata_i = first_data;
        tick();
        vec_cnt++;
        if ({status(), mem_addr_o} !== {6'b1_00_000, first_addr}) begin
            err_cnt++; $display("FAIL arb%0d_first_grant: got %b/%h expected 100000/%h", round, status(), mem_addr_o, first_addr);
        end
        tick();
        vec_cnt++;
        if ({status(), (first_d ? d_rdata_o : if_rdata_o)} !== {first_ack, first_data}) begin
            err_cnt++; $display("FAIL arb%0d_first_ack: got %b/%h expected %b/%h", round, status(), (first_d ? d_rdata_o : if_rdata_o), first_ack, first_data);
        end
        if (first_d) d_req_i = 1'b0; else if_req_i = 1'b0;
        mem_rdata_i = second_data;
        tick();
        vec_cnt++;
        if (status() !== 6'b0_00_000) begin
            err_cnt++; $display("FAIL arb%0d_gap: got %b expected 000000", round, status());
        end
        tick();
        vec_cnt++;
        if ({status(), mem_addr_o} !== {6'b1_00_000, second_addr}) begin
            err_cnt++; $display("FAIL arb%0d_second_grant: got %b/%h expected 100000/%h", round, status(), mem_addr_o, second_addr);
        end
        tick();
        vec_cnt++;
        if ({status(), (first_d ? if_rdata_o : d_rdata_o)} !== {second_ack, second_data}) begin
            err_cnt++; $display("FAIL arb%0d_second_ack: got %b/%h expected %b/%h", round, status(), (first_d ? if_rdata_o : d_rdata_o), second_ack, second_data);
        end
        if_req_i = 1'b0; d_req_i = 1'b0; mem_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        logic first_d;
`ifdef ARB_ROUND_ROBIN_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        arb_round(first_d, 0);
        arb_round(first_d, 1);
    endtask

    task automatic test_timeout();
        d_req_i = 1'b1; d_we_i = 2'b00; d_addr_i = 32'h0000_2100; d_wdata_i = 32'h0;
        mem_ready_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
        for (int i = 1; i <= 15; i++) begin
            tick();
            vec_cnt++;
            if ({status(), mem_addr_o} !== {6'b1_00_000, 32'h2100}) begin
                err_cnt++; $display("FAIL timeout_wait_%0d: got %b/%h expected 100000/00002100", i, status(), mem_addr_o);
            end
        end
        tick();
        d_req_i = 1'b0;
        vec_cnt++;
        if ({status(), d_rdata_o} !== {6'b0_00_011, 32'h0}) begin
            err_cnt++; $display("FAIL timeout_ack: got %b/%h expected 000011/00000000", status(), d_rdata_o);
        end
        tick();
        vec_cnt++;
        if (status() !== 6'b0_00_000) begin
            err_cnt++; $display("FAIL timeout_after: got %b expected 000000", status());
        end
    endtask

    task automatic test_byte_store();
        d_req_i = 1'b1; d_we_i = 2'b01; d_addr_i = 32'h0000_2003; d_wdata_i = 32'h0000_00A5;
        mem_ready_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        tick();
        vec_cnt++;
        if ({status(), mem_addr_o, mem_wdata_o} !== {6'b1_01_000, 32'h2003, 32'hA5}) begin
            err_cnt++; $display("FAIL byte_grant: got %b/%h/%h expected 101000/00002003/000000a5", status(), mem_addr_o, mem_wdata_o);
        end
        tick();
        d_req_i = 1'b0; mem_ready_i = 1'b0;
        vec_cnt++;
        if ({status(), d_rdata_o} !== {6'b0_00_010, 32'h0}) begin
            err_cnt++; $display("FAIL byte_ack: got %b/%h expected 000010/00000000", status(), d_rdata_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_store_wait_states();
        test_arbitration();
        test_timeout();
        test_byte_store();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
